hwag_sync_ctrl: RTL and testbench
=================================

HWAG_SYNC_CTRL -- requirements
Module: hwag_sync_ctrl

Interface
REQ-001 Parameter WIDTH, default 24: bit width of the period timer, the captures and the min/max limits.
REQ-002 Parameter TEETH, default 58: number of real teeth per revolution, excluding the gap.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port en_i, input, 1: enables synchronisation; 0 forces IDLE.
REQ-007 Port edge_i, input, 1: one-cycle pulse per tooth edge, already synchronised to clk.
REQ-008 Port min_i, input, WIDTH: minimum valid tooth period, in clocks.
REQ-009 Port max_i, input, WIDTH: maximum valid tooth period, in clocks; also the edge timeout.
REQ-010 Port synced_o, output, 1: high while in SYNCED.
REQ-011 Port tooth_o, output, 6: current tooth index, range 0..TEETH-1.
REQ-012 Port gap_o, output, 1: one-cycle pulse on an accepted gap.
REQ-013 Port err_o, output, 1: one-cycle pulse on any fault.
REQ-014 Port period_o, output, WIDTH: most recent capture (cap0).

Function
REQ-015 Timer: cleared to 0 in every edge_i cycle; otherwise increments by 1 per clock and saturates at all-ones.
REQ-016 Edge capture: in an edge_i cycle, cap2<=cap1, cap1<=cap0, cap0<=timer.
REQ-017 Period normality, evaluated with new=timer in the edge cycle:
- normal = (new>min_i && cap0>min_i && cap1>min_i) && (new<max_i || cap0<max_i).
REQ-018 Gap condition: new >= 2*cap0, compared at WIDTH+1 bits with no overflow.
REQ-019 States are IDLE, FILL, SEARCH and SYNCED.
REQ-020 IDLE -> FILL when en_i=1; the fill count is cleared on entry.
REQ-021 FILL: each edge increments the fill count; the third edge moves to SEARCH.
REQ-022 FILL: normality is not checked.
REQ-023 SEARCH: a normal edge meeting the gap condition -> SYNCED, with tooth_o<=0 and a gap_o pulse.
REQ-024 SEARCH: any other normal edge stays in SEARCH.
REQ-025 SYNCED: a normal non-gap edge sets tooth_o<=tooth_o+1, wrapping TEETH-1 -> 0.
REQ-026 SYNCED: a gap edge sets tooth_o<=0 and pulses gap_o.
REQ-027 SEARCH or SYNCED: an edge failing normality pulses err_o and moves to FILL.
REQ-028 Timeout: in FILL, SEARCH or SYNCED, a non-edge cycle with timer >= max_i pulses err_o once and moves to FILL.
REQ-029 When edge_i and the timeout coincide in one cycle, edge_i wins and no timeout is raised.
REQ-030 Latency: all outputs are registered and reflect edge-cycle N decisions at cycle N+1.
REQ-031 en_i=0 in any state -> IDLE next cycle; synced_o, tooth_o, gap_o and err_o are cleared; the timer and captures are held.

Reset
REQ-032 rst=1 SHALL force, at the next clock: IDLE, timer=0, cap0/1/2=0, fill count=0, and all outputs 0.
REQ-033 Reset SHALL take priority over en_i and edge_i, including in mid-revolution.

Configuration
REQ-034 The macro HWAG_GAP_VERIFY_EN SHALL select strict gap checking.
REQ-035 Macro defined, error cases:
- gap edge while tooth_o != TEETH-1 -> err_o pulse, move to SEARCH;
- non-gap edge while tooth_o == TEETH-1 (missing gap) -> err_o pulse, move to SEARCH.
REQ-036 Macro defined, normal case: a gap is accepted only at tooth_o == TEETH-1.
REQ-037 Macro undefined: any gap edge re-aligns tooth_o to 0 and the block stays in SYNCED.
REQ-038 Macro undefined: the tooth index wraps silently with no error.

Structure
REQ-039 Package hwag_pkg SHALL hold the state enum, the default WIDTH and TEETH constants, and the fill depth (3).
REQ-040 The normality check SHALL be a period_normal instance; it is the only sub-module.
REQ-041 The timer, captures and FSM SHALL be in hwag_sync_ctrl.

Verification (WIDTH=16, TEETH=58, min_i=10, max_i=1000)
REQ-042 Scenario reset: rst held 2 cycles -> all outputs 0, state IDLE.
REQ-043 Scenario lock: en_i=1, 3 edges at period 100, then 1 edge at period 300 -> one cycle after that edge, synced_o=1, tooth_o=0, gap_o pulse.
REQ-044 Scenario revolution: 57 edges at period 100 -> tooth_o=57; next edge at 300 -> gap_o pulse, tooth_o=0, err_o=0.
REQ-045 Scenario timeout: no edge for 1000 cycles in SYNCED -> single err_o pulse, synced_o=0, state FILL.
REQ-046 Scenario early gap: period 300 at tooth_o=30:
- macro on -> err_o pulse, state SEARCH;
- macro off -> tooth_o=0, synced_o stays 1.
REQ-047 Scenario short period: edge at period 5 in SYNCED -> err_o pulse, state FILL, synced_o=0.

Source files
------------

// File: rtl/hwag_pkg.sv
// -----------------------------------------------------------------------------
// hwag_pkg
// Shared definitions for the crank-wheel synchronisation controller:
// the FSM state encoding, default WIDTH/TEETH values and the fill depth
// (number of edges collected before gap searching may start).
// -----------------------------------------------------------------------------
package hwag_pkg;

    localparam int HWAG_WIDTH_DEF  = 24;
    localparam int HWAG_TEETH_DEF  = 58;
    localparam int HWAG_FILL_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_SYNCED = 2'd3
    } hwag_state_e;

endpackage

// File: rtl/period_normal.sv
// -----------------------------------------------------------------------------
// period_normal
// Plausibility check of a tooth period against the two previous captures.
// A period is normal when the new period and both history periods are above
// the minimum, and at least one of new/cap0 is below the maximum (so a gap,
// which is about twice a tooth, is tolerated next to a regular tooth).
// Ports:
//   i_new   - period measured in the current edge cycle
//   i_cap0  - most recent stored capture
//   i_cap1  - capture before i_cap0
//   i_min   - minimum valid period (exclusive)
//   i_max   - maximum valid period (exclusive)
//   o_normal- 1 when the period sequence is plausible
// -----------------------------------------------------------------------------
module period_normal #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] i_new,
    input  logic [WIDTH-1:0] i_cap0,
    input  logic [WIDTH-1:0] i_cap1,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_max,
    output logic             o_normal
);

    assign o_normal = (i_new > i_min) && (i_cap0 > i_min) && (i_cap1 > i_min) &&
                      ((i_new < i_max) || (i_cap0 < i_max));

endmodule

// File: rtl/hwag_sync_ctrl.sv
// -----------------------------------------------------------------------------
// hwag_sync_ctrl
// Crank-wheel synchroniser for a TEETH+gap trigger wheel. Measures tooth
// periods with a saturating timer, keeps three captures, detects the gap
// (period >= 2x previous) and tracks the tooth index once synchronised.
// Optional macro HWAG_GAP_VERIFY_EN: strict gap checking, a gap is only
// accepted after tooth TEETH-1 and a misplaced/missing gap drops to SEARCH.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en_i      - enable; 0 forces IDLE and clears the status outputs
//   edge_i    - one-cycle pulse per tooth edge
//   min_i     - minimum valid tooth period (clocks)
//   max_i     - maximum valid tooth period, also the edge timeout
//   synced_o  - high while synchronised
//   tooth_o   - current tooth index 0..TEETH-1
//   gap_o     - one-cycle pulse on an accepted gap
//   err_o     - one-cycle pulse on any fault
//   period_o  - most recent capture
// -----------------------------------------------------------------------------
module hwag_sync_ctrl
    import hwag_pkg::*;
#(
    parameter int WIDTH = HWAG_WIDTH_DEF,
    parameter int TEETH = HWAG_TEETH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             edge_i,
    input  logic [WIDTH-1:0] min_i,
    input  logic [WIDTH-1:0] max_i,
    output logic             synced_o,
    output logic [5:0]       tooth_o,
    output logic             gap_o,
    output logic             err_o,
    output logic [WIDTH-1:0] period_o
);

    localparam logic [5:0] LAST_TOOTH = 6'(TEETH - 1);
    localparam logic [1:0] FILL_LAST  = 2'(HWAG_FILL_DEPTH - 1);

    hwag_state_e      r_state;
    hwag_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_timer;
    logic [WIDTH-1:0] r_cap0;
    logic [WIDTH-1:0] r_cap1;
    logic [WIDTH-1:0] r_cap2;
    logic [1:0]       r_fill;
    logic [1:0]       w_fill_nxt;
    logic             r_to_done;
    logic             r_synced;
    logic [5:0]       r_tooth;
    logic             r_gap;
    logic             r_err;
    logic             w_synced_nxt;
    logic [5:0]       w_tooth_nxt;
    logic             w_gap_nxt;
    logic             w_err_nxt;
    logic             w_normal;
    logic             w_gap;
    logic             w_timeout;
    logic             w_unused_cap2;

    // cap2 is kept as capture history only; no decision consumes it.
    assign w_unused_cap2 = ^r_cap2;

    period_normal #(.WIDTH(WIDTH)) u_period_normal (
        .i_new    (r_timer),
        .i_cap0   (r_cap0),
        .i_cap1   (r_cap1),
        .i_min    (min_i),
        .i_max    (max_i),
        .o_normal (w_normal)
    );

    // Gap compare at WIDTH+1 bits so doubling cap0 cannot overflow.
    assign w_gap = {1'b0, r_timer} >= {r_cap0, 1'b0};

    // Timeout fires once per silent stretch; r_to_done blocks repeats until the next edge.
    assign w_timeout = (r_state != ST_IDLE) && !edge_i && (r_timer >= max_i) && !r_to_done;

    // Period timer, capture history and timeout latch; all held while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= {WIDTH{1'b0}};
            r_cap0    <= {WIDTH{1'b0}};
            r_cap1    <= {WIDTH{1'b0}};
            r_cap2    <= {WIDTH{1'b0}};
            r_to_done <= 1'b0;
        end else if (!en_i) begin
            r_to_done <= 1'b0;
        end else if (edge_i) begin
            r_timer   <= {WIDTH{1'b0}};
            r_cap0    <= r_timer;
            r_cap1    <= r_cap0;
            r_cap2    <= r_cap1;
            r_to_done <= 1'b0;
        end else begin
            if (r_timer != {WIDTH{1'b1}}) begin
                r_timer <= r_timer + {{(WIDTH-1){1'b0}}, 1'b1};
            end
            if (w_timeout) begin
                r_to_done <= 1'b1;
            end
        end
    end

    // FSM state, fill counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_fill   <= 2'd0;
            r_synced <= 1'b0;
            r_tooth  <= 6'd0;
            r_gap    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fill   <= w_fill_nxt;
            r_synced <= w_synced_nxt;
            r_tooth  <= w_tooth_nxt;
            r_gap    <= w_gap_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state and fill-count decision.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        if (!en_i) begin
            w_state_nxt = ST_IDLE;
            w_fill_nxt  = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_FILL;
                    w_fill_nxt  = 2'd0;
                end
                ST_FILL: begin
                    if (edge_i) begin
                        if (r_fill == FILL_LAST) begin
                            w_state_nxt = ST_SEARCH;
                            w_fill_nxt  = 2'd0;
                        end else begin
                            w_fill_nxt  = r_fill + 2'd1;
                        end
                    end else if (w_timeout) begin
                        w_fill_nxt = 2'd0;
                    end else begin
                        w_fill_nxt = r_fill;
                    end
                end
                ST_SEARCH: begin
                    if (edge_i) begin
                        if (!w_normal) begin
                            w_state_nxt = ST_FILL;
                            w_fill_nxt  = 2'd0;
                        end else if (w_gap) begin
                            w_state_nxt = ST_SYNCED;
                        end else begin
                            w_state_nxt = ST_SEARCH;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt = ST_FILL;
                        w_fill_nxt  = 2'd0;
                    end else begin
                        w_state_nxt = ST_SEARCH;
                    end
                end
                ST_SYNCED: begin
                    if (edge_i) begin
                        if (!w_normal) begin
                            w_state_nxt = ST_FILL;
                            w_fill_nxt  = 2'd0;
`ifdef HWAG_GAP_VERIFY_EN
                        end else if (w_gap != (r_tooth == LAST_TOOTH)) begin
                            w_state_nxt = ST_SEARCH;
`endif
                        end else begin
                            w_state_nxt = ST_SYNCED;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt = ST_FILL;
                        w_fill_nxt  = 2'd0;
                    end else begin
                        w_state_nxt = ST_SYNCED;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_fill_nxt  = 2'd0;
                end
            endcase
        end
    end

    // Next values of the status outputs.
    always_comb begin
        w_synced_nxt = (w_state_nxt == ST_SYNCED);
        w_tooth_nxt  = r_tooth;
        w_gap_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        if (!en_i) begin
            w_tooth_nxt = 6'd0;
        end else begin
            case (r_state)
                ST_SEARCH, ST_SYNCED: begin
                    if (edge_i) begin
                        if (!w_normal) begin
                            w_err_nxt   = 1'b1;
                            w_tooth_nxt = 6'd0;
                        end else if (r_state == ST_SEARCH) begin
                            if (w_gap) begin
                                w_tooth_nxt = 6'd0;
                                w_gap_nxt   = 1'b1;
                            end else begin
                                w_tooth_nxt = r_tooth;
                            end
`ifdef HWAG_GAP_VERIFY_EN
                        end else if (w_gap && (r_tooth == LAST_TOOTH)) begin
                            w_tooth_nxt = 6'd0;
                            w_gap_nxt   = 1'b1;
                        end else if (w_gap || (r_tooth == LAST_TOOTH)) begin
                            w_err_nxt   = 1'b1;
                            w_tooth_nxt = 6'd0;
`else
                        end else if (w_gap) begin
                            w_tooth_nxt = 6'd0;
                            w_gap_nxt   = 1'b1;
                        end else if (r_tooth == LAST_TOOTH) begin
                            w_tooth_nxt = 6'd0;
`endif
                        end else begin
                            w_tooth_nxt = r_tooth + 6'd1;
                        end
                    end else if (w_timeout) begin
                        w_err_nxt   = 1'b1;
                        w_tooth_nxt = 6'd0;
                    end else begin
                        w_tooth_nxt = r_tooth;
                    end
                end
                ST_FILL: begin
                    w_tooth_nxt = 6'd0;
                    w_err_nxt   = w_timeout;
                end
                default: begin
                    w_tooth_nxt = 6'd0;
                end
            endcase
        end
    end

    assign synced_o = r_synced;
    assign tooth_o  = r_tooth;
    assign gap_o    = r_gap;
    assign err_o    = r_err;
    assign period_o = r_cap0;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hwag_sync_ctrl
// Directed bench for hwag_sync_ctrl at WIDTH=16, TEETH=58, min=10, max=1000.
// send_edge(n) leaves edge_i low for n cycles then pulses it, so the timer
// value seen in that edge cycle (the captured period) is n.
// -----------------------------------------------------------------------------
module tb_hwag_sync_ctrl;
    import hwag_pkg::*;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic             edge_i;
    logic [WIDTH-1:0] min_i;
    logic [WIDTH-1:0] max_i;
    logic             synced_o;
    logic [5:0]       tooth_o;
    logic             gap_o;
    logic             err_o;
    logic [WIDTH-1:0] period_o;

    int tests = 0;
    int fails = 0;

    hwag_sync_ctrl #(.WIDTH(WIDTH), .TEETH(58)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .edge_i   (edge_i),
        .min_i    (min_i),
        .max_i    (max_i),
        .synced_o (synced_o),
        .tooth_o  (tooth_o),
        .gap_o    (gap_o),
        .err_o    (err_o),
        .period_o (period_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_edge(input int n);
        edge_i = 1'b0;
        repeat (n) tick();
        edge_i = 1'b1;
        tick();
        edge_i = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int errs;
        rst    = 1'b1;
        en_i   = 1'b0;
        edge_i = 1'b0;
        min_i  = 16'd10;
        max_i  = 16'd1000;

        // Reset held two cycles
        tick();
        tick();
        chk("rst_synced", 32'(synced_o), 32'd0);
        chk("rst_tooth",  32'(tooth_o),  32'd0);
        chk("rst_gap",    32'(gap_o),    32'd0);
        chk("rst_err",    32'(err_o),    32'd0);
        chk("rst_period", 32'(period_o), 32'd0);
        chk("rst_state",  32'(dut.r_state), 32'(ST_IDLE));
        rst = 1'b0;

        // Lock: three fill edges, then a gap
        en_i = 1'b1;
        tick();
        chk("lock_fill", 32'(dut.r_state), 32'(ST_FILL));
        repeat (3) send_edge(100);
        chk("lock_search", 32'(dut.r_state), 32'(ST_SEARCH));
        send_edge(300);
        chk("lock_synced", 32'(synced_o), 32'd1);
        chk("lock_tooth",  32'(tooth_o),  32'd0);
        chk("lock_gap",    32'(gap_o),    32'd1);
        chk("lock_err",    32'(err_o),    32'd0);
        chk("lock_period", 32'(period_o), 32'd300);
        tick();
        chk("lock_gap_pulse", 32'(gap_o), 32'd0);

        // Full revolution
        repeat (57) send_edge(100);
        chk("rev_tooth57", 32'(tooth_o), 32'd57);
        send_edge(300);
        chk("rev_gap",    32'(gap_o),    32'd1);
        chk("rev_tooth0", 32'(tooth_o),  32'd0);
        chk("rev_err",    32'(err_o),    32'd0);
        chk("rev_synced", 32'(synced_o), 32'd1);

        // Timeout in SYNCED: exactly one error pulse
        errs = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (err_o) errs++;
        end
        chk("to_err_count", 32'(errs), 32'd1);
        chk("to_synced",    32'(synced_o), 32'd0);
        chk("to_state",     32'(dut.r_state), 32'(ST_FILL));

        // Relock then early gap at tooth 30
        repeat (3) send_edge(100);
        send_edge(300);
        chk("relock_synced", 32'(synced_o), 32'd1);
        repeat (30) send_edge(100);
        chk("early_tooth30", 32'(tooth_o), 32'd30);
        send_edge(300);
`ifdef HWAG_GAP_VERIFY_EN
        chk("early_err",    32'(err_o),    32'd1);
        chk("early_state",  32'(dut.r_state), 32'(ST_SEARCH));
        chk("early_synced", 32'(synced_o), 32'd0);
`else
        chk("early_err",    32'(err_o),    32'd0);
        chk("early_tooth",  32'(tooth_o),  32'd0);
        chk("early_synced", 32'(synced_o), 32'd1);
        chk("early_gap",    32'(gap_o),    32'd1);
`endif
        send_edge(100);
        send_edge(300);
        chk("resync_synced", 32'(synced_o), 32'd1);
        chk("resync_tooth",  32'(tooth_o),  32'd0);

        // Short period while SYNCED
        send_edge(5);
        chk("short_err",    32'(err_o),    32'd1);
        chk("short_synced", 32'(synced_o), 32'd0);
        chk("short_state",  32'(dut.r_state), 32'(ST_FILL));

        // Disable while SYNCED
        repeat (3) send_edge(100);
        send_edge(300);
        repeat (2) send_edge(100);
        chk("dis_tooth2", 32'(tooth_o), 32'd2);
        en_i = 1'b0;
        tick();
        chk("dis_synced", 32'(synced_o), 32'd0);
        chk("dis_tooth",  32'(tooth_o),  32'd0);
        chk("dis_state",  32'(dut.r_state), 32'(ST_IDLE));

        // Reset mid-revolution with a coincident edge
        en_i = 1'b1;
        tick();
        repeat (3) send_edge(100);
        send_edge(300);
        send_edge(100);
        chk("mid_tooth1", 32'(tooth_o), 32'd1);
        rst    = 1'b1;
        edge_i = 1'b1;
        tick();
        chk("mid_rst_synced", 32'(synced_o), 32'd0);
        chk("mid_rst_tooth",  32'(tooth_o),  32'd0);
        chk("mid_rst_period", 32'(period_o), 32'd0);
        chk("mid_rst_timer",  32'(dut.r_timer), 32'd0);
        chk("mid_rst_state",  32'(dut.r_state), 32'(ST_IDLE));
        rst    = 1'b0;
        edge_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
